// File: rtl/bootstrap_copier.sv
// bootstrap_copier: boot-time EEPROM->SRAM shadow copier, then RAM/VIA/ACIA chip-select decoder.
// Optional feature macro: CHECKSUM_EN (adds the checksum output and accumulator).
`default_nettype none

module bootstrap_copier #(
    parameter int          ADDR_WIDTH   = 16,
    parameter int unsigned COPY_BASE    = 32'hE000,
    parameter int          COPY_LEN     = 8192,
    parameter int          SETUP_CYCLES = 1,
    parameter int          WE_CYCLES    = 1,
    parameter int unsigned IO_BASE      = 32'hD000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    inout  wire  [ADDR_WIDTH-1:0] address,
    input  logic [7:0]            data,
    inout  wire                   ram_we_n,
    output logic                  ram_cs_n,
    inout  wire                   eeprom_oe_n,
    output logic                  eeprom_cs_n,
    output logic                  via_ce_n,
    output logic                  acia_ce_n,
    output logic                  cpu_reset_n,
    output logic                  done
`ifdef CHECKSUM_EN
    ,
    output logic [7:0]            checksum
`endif
);

    localparam int CNT_W    = (COPY_LEN > 1) ? $clog2(COPY_LEN) : 1;
    localparam int WAIT_MAX = (SETUP_CYCLES > WE_CYCLES) ? SETUP_CYCLES : WE_CYCLES;
    localparam int WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    localparam logic [CNT_W-1:0]      LAST_BYTE  = CNT_W'(COPY_LEN - 1);
    localparam logic [WAIT_W-1:0]     SETUP_LAST = WAIT_W'(SETUP_CYCLES - 1);
    localparam logic [WAIT_W-1:0]     WE_LAST    = WAIT_W'(WE_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE_A     = ADDR_WIDTH'(COPY_BASE);
    localparam logic [ADDR_WIDTH-1:0] IO_A       = ADDR_WIDTH'(IO_BASE);

    typedef enum logic [1:0] {
        SETUP = 2'd0,
        WRITE = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state, state_next;
    logic [CNT_W-1:0]    count, count_next;
    logic [WAIT_W-1:0]   wait_cnt, wait_next;
    logic                we_n_int;
    logic                copying;
    logic [ADDR_WIDTH-1:0] copy_addr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= SETUP;
            count    <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            count    <= count_next;
            wait_cnt <= wait_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        wait_next  = wait_cnt;
        we_n_int   = 1'b1;
        case (state)
            SETUP: begin
                if (wait_cnt == SETUP_LAST) begin
                    state_next = WRITE;
                    wait_next  = '0;
                end else begin
                    wait_next = wait_cnt + 1'b1;
                end
            end
            WRITE: begin
                we_n_int = 1'b0;
                if (wait_cnt == WE_LAST) begin
                    state_next = HOLD;
                    wait_next  = '0;
                end else begin
                    wait_next = wait_cnt + 1'b1;
                end
            end
            HOLD: begin
                // Address only moves here, after WE has already risen.
                if (count == LAST_BYTE) begin
                    state_next = DONE;
                end else begin
                    count_next = count + 1'b1;
                    state_next = SETUP;
                end
            end
            default: state_next = DONE;
        endcase
    end

    assign copying     = (state != DONE);
    assign copy_addr   = BASE_A + ADDR_WIDTH'(count);
    assign done        = ~copying;
    assign cpu_reset_n = ~copying;

    assign address     = copying ? copy_addr : {ADDR_WIDTH{1'bz}};
    assign ram_we_n    = copying ? we_n_int  : 1'bz;
    assign eeprom_oe_n = copying ? 1'b0      : 1'bz;

    logic io_hit;
    logic via_hit;
    logic acia_hit;

    assign io_hit   = (address[ADDR_WIDTH-1:8] == IO_A[ADDR_WIDTH-1:8]);
    assign via_hit  = io_hit && (address[7:4] == 4'h0);
    assign acia_hit = io_hit && (address[7:4] == 4'h1);

    always_comb begin
        eeprom_cs_n = 1'b0;
        ram_cs_n    = 1'b0;
        via_ce_n    = 1'b1;
        acia_ce_n   = 1'b1;
        if (!copying) begin
            eeprom_cs_n = 1'b1;
            ram_cs_n    = io_hit;
            via_ce_n    = ~via_hit;
            acia_ce_n   = ~acia_hit;
        end
    end

`ifdef CHECKSUM_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            checksum <= 8'h00;
        end else if (state == WRITE && wait_cnt == WE_LAST) begin
            checksum <= checksum + data;
        end
    end
`else
    logic unused_data;
    assign unused_data = ^data;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bootstrap_copier.sv
// tb_bootstrap_copier: checks copy timing, mid-copy reset, full-range copy and the post-copy decoder.
`default_nettype none

module tb_bootstrap_copier;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [15:0] addr;
        logic        we_n;
        logic        done;
    } exp_t;

    // Copy timeline derived directly from the per-byte period.
    function automatic exp_t model(input int k, input int s, input int w, input int len, input int base);
        exp_t e;
        int p, b, ph;
        p      = s + w + 1;
        b      = k / p;
        ph     = k % p;
        e.done = (k >= len * p);
        e.addr = 16'(base + b);
        e.we_n = e.done || !(ph >= s && ph < s + w);
        return e;
    endfunction

    typedef struct packed {
        logic via_n;
        logic acia_n;
        logic ram_n;
    } sel_t;

    function automatic sel_t decode_model(input logic [15:0] a);
        sel_t r;
        int   off;
        off = int'(a) - 32'hD000;
        r   = '{via_n: 1'b1, acia_n: 1'b1, ram_n: 1'b1};
        if (off >= 0 && off < 256) begin
            if (off < 16)      r.via_n  = 1'b0;
            else if (off < 32) r.acia_n = 1'b0;
        end else begin
            r.ram_n = 1'b0;
        end
        return r;
    endfunction

    // ---------------- DUT A: 4 bytes at 0x0010, default timing ----------------
    logic        a_rst = 1'b0;
    logic        a_cpu_en = 1'b0;
    logic [15:0] a_cpu_addr = '0;
    wire  [15:0] a_addr;
    wire         a_we, a_oe;
    logic        a_ram, a_eep, a_via, a_acia, a_cpu, a_done;
    assign a_addr = a_cpu_en ? a_cpu_addr : 16'hzzzz;

    // ---------------- DUT B: 8 bytes at 0x0100, SETUP=3 WE=2 ----------------
    logic        b_rst = 1'b0;
    wire  [15:0] b_addr;
    wire         b_we, b_oe;
    logic        b_ram, b_eep, b_via, b_acia, b_cpu, b_done;

    // ---------------- DUT C: default full copy ----------------
    logic        c_rst = 1'b0;
    wire  [15:0] c_addr;
    wire         c_we, c_oe;
    logic        c_ram, c_eep, c_via, c_acia, c_cpu, c_done;

    logic [7:0]  zero_data = 8'h00;

`ifdef CHECKSUM_EN
    logic [7:0]  a_sum, b_sum, c_sum, d_sum;
    logic        d_rst = 1'b0;
    logic [7:0]  d_data = 8'h00;
    wire  [15:0] d_addr;
    wire         d_we, d_oe;
    logic        d_ram, d_eep, d_via, d_acia, d_cpu, d_done;

    bootstrap_copier #(.COPY_BASE(32'h0000), .COPY_LEN(3)) u_d (
        .clock(clock), .reset_n(d_rst), .address(d_addr), .data(d_data),
        .ram_we_n(d_we), .ram_cs_n(d_ram), .eeprom_oe_n(d_oe), .eeprom_cs_n(d_eep),
        .via_ce_n(d_via), .acia_ce_n(d_acia), .cpu_reset_n(d_cpu), .done(d_done),
        .checksum(d_sum)
    );
`endif

    bootstrap_copier #(.COPY_BASE(32'h0010), .COPY_LEN(4)) u_a (
        .clock(clock), .reset_n(a_rst), .address(a_addr), .data(zero_data),
        .ram_we_n(a_we), .ram_cs_n(a_ram), .eeprom_oe_n(a_oe), .eeprom_cs_n(a_eep),
        .via_ce_n(a_via), .acia_ce_n(a_acia), .cpu_reset_n(a_cpu), .done(a_done)
`ifdef CHECKSUM_EN
        , .checksum(a_sum)
`endif
    );

    bootstrap_copier #(.COPY_BASE(32'h0100), .COPY_LEN(8), .SETUP_CYCLES(3), .WE_CYCLES(2)) u_b (
        .clock(clock), .reset_n(b_rst), .address(b_addr), .data(zero_data),
        .ram_we_n(b_we), .ram_cs_n(b_ram), .eeprom_oe_n(b_oe), .eeprom_cs_n(b_eep),
        .via_ce_n(b_via), .acia_ce_n(b_acia), .cpu_reset_n(b_cpu), .done(b_done)
`ifdef CHECKSUM_EN
        , .checksum(b_sum)
`endif
    );

    bootstrap_copier u_c (
        .clock(clock), .reset_n(c_rst), .address(c_addr), .data(zero_data),
        .ram_we_n(c_we), .ram_cs_n(c_ram), .eeprom_oe_n(c_oe), .eeprom_cs_n(c_eep),
        .via_ce_n(c_via), .acia_ce_n(c_acia), .cpu_reset_n(c_cpu), .done(c_done)
`ifdef CHECKSUM_EN
        , .checksum(c_sum)
`endif
    );

    typedef struct packed {
        logic [15:0] addr;
        sel_t        exp;
    } dec_vec_t;

    dec_vec_t tbl [10];

    initial begin
        exp_t        e;
        sel_t        m;
        logic [15:0] ra;
        logic [15:0] prev_addr;
        logic [15:0] last_addr;
        int          cut;

        tbl[0] = '{16'hD005, '{1'b0, 1'b1, 1'b1}};
        tbl[1] = '{16'hD013, '{1'b1, 1'b0, 1'b1}};
        tbl[2] = '{16'hD080, '{1'b1, 1'b1, 1'b1}};
        tbl[3] = '{16'h1234, '{1'b1, 1'b1, 1'b0}};
        tbl[4] = '{16'hD00F, '{1'b0, 1'b1, 1'b1}};
        tbl[5] = '{16'hD010, '{1'b1, 1'b0, 1'b1}};
        tbl[6] = '{16'hD01F, '{1'b1, 1'b0, 1'b1}};
        tbl[7] = '{16'hD0FF, '{1'b1, 1'b1, 1'b1}};
        tbl[8] = '{16'hCFFF, '{1'b1, 1'b1, 1'b0}};
        tbl[9] = '{16'hD100, '{1'b1, 1'b1, 1'b0}};

        repeat (3) @(negedge clock);

        // ---- A: reset state ----
        check("a_rst_addr", a_addr, 16'h0010);
        check("a_rst_we", a_we, 1'b1);
        check("a_rst_oe", a_oe, 1'b0);
        check("a_rst_ram", a_ram, 1'b0);
        check("a_rst_eep", a_eep, 1'b0);
        check("a_rst_via", a_via, 1'b1);
        check("a_rst_acia", a_acia, 1'b1);
        check("a_rst_cpu", a_cpu, 1'b0);
        check("a_rst_done", a_done, 1'b0);

        // ---- A: copy timeline, done at cycle 12 ----
        a_rst = 1'b1;
        for (int k = 0; k <= 14; k++) begin
            if (k > 0) @(negedge clock);
            e = model(k, 1, 1, 4, 32'h0010);
            check("a_done", a_done, e.done);
            check("a_cpu_reset", a_cpu, e.done);
            check("a_eep_cs", a_eep, e.done);
            if (!e.done) begin
                check("a_addr", a_addr, e.addr);
                check("a_we", a_we, e.we_n);
                check("a_ram_cs", a_ram, 1'b0);
                check("a_via", a_via, 1'b1);
                check("a_acia", a_acia, 1'b1);
            end
        end

        // ---- A: decode table after done ----
        a_cpu_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a_cpu_addr = tbl[i].addr;
            #1;
            check("dec_via", a_via, tbl[i].exp.via_n);
            check("dec_acia", a_acia, tbl[i].exp.acia_n);
            check("dec_ram", a_ram, tbl[i].exp.ram_n);
            check("dec_eep", a_eep, 1'b1);
        end
        for (int i = 0; i < 40; i++) begin
            ra = (i % 2 == 0) ? 16'($urandom_range(32'hD000, 32'hD0FF)) : 16'($urandom);
            a_cpu_addr = ra;
            #1;
            m = decode_model(ra);
            check("rnd_via", a_via, m.via_n);
            check("rnd_acia", a_acia, m.acia_n);
            check("rnd_ram", a_ram, m.ram_n);
            check("rnd_done", a_done, 1'b1);
        end

        // ---- B: slow timing, reset asserted during byte 2 ----
        @(negedge clock);
        b_rst     = 1'b1;
        prev_addr = 16'h0100;
        cut       = 12 + $urandom_range(0, 5);
        for (int k = 0; k <= cut; k++) begin
            if (k > 0) @(negedge clock);
            e = model(k, 3, 2, 8, 32'h0100);
            check("b_addr", b_addr, e.addr);
            check("b_we", b_we, e.we_n);
            if (b_we == 1'b0) check("b_addr_stable", b_addr, prev_addr);
            prev_addr = b_addr;
        end
        #2 b_rst = 1'b0;
        #1;
        check("b_async_addr", b_addr, 16'h0100);
        check("b_async_we", b_we, 1'b1);
        check("b_async_done", b_done, 1'b0);
        check("b_async_cpu", b_cpu, 1'b0);
        check("b_async_eep", b_eep, 1'b0);
        @(negedge clock);
        b_rst     = 1'b1;
        prev_addr = 16'h0100;
        for (int k = 0; k <= 50; k++) begin
            if (k > 0) @(negedge clock);
            e = model(k, 3, 2, 8, 32'h0100);
            check("b2_done", b_done, e.done);
            check("b2_cpu", b_cpu, e.done);
            if (!e.done) begin
                check("b2_addr", b_addr, e.addr);
                check("b2_we", b_we, e.we_n);
                check("b2_via", b_via, 1'b1);
                if (b_we == 1'b0) check("b2_addr_stable", b_addr, prev_addr);
                prev_addr = b_addr;
            end
        end

        // ---- C: default full copy to 0xFFFF ----
        @(negedge clock);
        c_rst     = 1'b1;
        last_addr = 16'h0000;
        for (int k = 0; k <= 24576; k++) begin
            if (k > 0) @(negedge clock);
            e = model(k, 1, 1, 8192, 32'hE000);
            check("c_done", c_done, e.done);
            if (!e.done) begin
                check("c_addr", c_addr, e.addr);
                check("c_we", c_we, e.we_n);
                last_addr = c_addr;
            end
        end
        check("c_last_addr", last_addr, 16'hFFFF);
        check("c_eep_final", c_eep, 1'b1);

`ifdef CHECKSUM_EN
        begin
            logic [7:0] vals [3];
            vals[0] = 8'hF0;
            vals[1] = 8'h20;
            vals[2] = 8'h05;
            check("d_sum_rst", d_sum, 8'h00);
            @(negedge clock);
            d_rst = 1'b1;
            for (int k = 0; k <= 11; k++) begin
                if (k > 0) @(negedge clock);
                d_data = vals[(k / 3 > 2) ? 2 : k / 3];
            end
            check("d_done", d_done, 1'b1);
            check("d_sum", d_sum, 8'h15);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
